// File: rtl/stream_mux_pkg.sv
// Shared constants and the round-robin search function for the stream
// arbiter/mux.
package stream_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;
  localparam int MAX_NCH  = 16;

  // Result of a round-robin search: whether any request won, and which one.
  typedef struct packed {
    logic       any;
    logic [3:0] idx;
  } rr_gnt_t;

  // First requester found searching from ptr+1 upward, wrapping modulo nch.
  // Both arguments are zero-extended to the largest supported channel count.
  function automatic rr_gnt_t rr_grant(input logic [MAX_NCH-1:0] req,
                                       input logic [3:0]         ptr,
                                       input int                 nch);
    rr_gnt_t g;
    int      c;
    g = '0;
    for (int k = 1; k <= MAX_NCH; k++) begin
      c = (int'(ptr) + k) % nch;
      if (k <= nch && !g.any && req[c[3:0]]) begin
        g.any = 1'b1;
        g.idx = c[3:0];
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant search: picks the first asserted request after ptr.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] ptr,
  output logic [$clog2(NCH)-1:0] gnt_idx,
  output logic                   gnt_any
);

  rr_gnt_t g;

  // Purely combinational search; the pointer lives in the parent.
  always_comb begin
    g       = rr_grant(MAX_NCH'(req), 4'(ptr), NCH);
    gnt_any = g.any;
    gnt_idx = g.idx[$clog2(NCH)-1:0];
  end

endmodule

// File: rtl/stream_arb_mux.sv
// N-channel valid/ready stream mux with a single registered output slot.
// Channel choice is either an explicit index (MODE_SEL) or round-robin
// (MODE_RR). The output register accepts a new word whenever it is empty
// or being drained in the same cycle, giving full throughput.
module stream_arb_mux
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int MODE  = MODE_RR
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [$clog2(NCH)-1:0] sel,
  input  logic [NCH-1:0]         in_valid,
  input  logic [NCH*WIDTH-1:0]   in_data,
  output logic [NCH-1:0]         in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [$clog2(NCH)-1:0] out_ch,
  input  logic                   out_ready
);

  localparam int PW = $clog2(NCH);

  logic [PW-1:0] ptr;
  logic [PW-1:0] rr_idx;
  logic          rr_any;
  logic [PW-1:0] gnt_idx;
  logic          gnt_any;
  logic          load;
  logic          take;

  rr_arbiter #(.NCH(NCH)) u_rr (
    .req     (in_valid),
    .ptr     (ptr),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Grant selection and per-channel ready; never looks at in_data.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    gnt_idx  = '0;
    gnt_any  = 1'b0;
    in_ready = '0;
    load     = !out_valid || out_ready;
    if (MODE == MODE_RR) begin
      gnt_idx = rr_idx;
      gnt_any = rr_any;
    end else begin
      gnt_idx = sel;
      gnt_any = (int'(sel) < NCH);
    end
    if (gnt_any && load && !rst) in_ready[gnt_idx] = 1'b1;
    take = |(in_valid & in_ready);
  end

  // Output slot and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge
    // values regardless of statement order.
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= PW'(NCH - 1);
    end else if (take) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gnt_idx*WIDTH +: WIDTH];
      out_ch    <= gnt_idx;
      if (MODE == MODE_RR) ptr <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed self-checking bench for stream_arb_mux: a round-robin instance,
// a select-mode instance (NCH=4) and a select-mode instance with NCH=5 so
// that an out-of-range sel value is representable.
module tb_stream_arb_mux;
  import stream_mux_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic [3:0]  rr_in_ready;
  logic        rr_out_valid;
  logic [7:0]  rr_out_data;
  logic [1:0]  rr_out_ch;

  logic [3:0]  s_in_ready;
  logic        s_out_valid;
  logic [7:0]  s_out_data;
  logic [1:0]  s_out_ch;

  logic [2:0]  sel5;
  logic [4:0]  in_valid5;
  logic [39:0] in_data5;
  logic [4:0]  f_in_ready;
  logic        f_out_valid;
  logic [7:0]  f_out_data;
  logic [2:0]  f_out_ch;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_arb_mux #(.WIDTH(8), .NCH(4), .MODE(MODE_RR)) dut_rr (
    .clk(clk), .rst(rst), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_data(rr_out_data),
    .out_ch(rr_out_ch), .out_ready(out_ready)
  );

  stream_arb_mux #(.WIDTH(8), .NCH(4), .MODE(MODE_SEL)) dut_sel (
    .clk(clk), .rst(rst), .sel(sel), .in_valid(in_valid), .in_data(in_data),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
    .out_ch(s_out_ch), .out_ready(out_ready)
  );

  stream_arb_mux #(.WIDTH(8), .NCH(5), .MODE(MODE_SEL)) dut_sel5 (
    .clk(clk), .rst(rst), .sel(sel5), .in_valid(in_valid5), .in_data(in_data5),
    .in_ready(f_in_ready), .out_valid(f_out_valid), .out_data(f_out_data),
    .out_ch(f_out_ch), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    sel       = 2'd0;
    in_valid  = 4'b1111;
    in_data   = 32'h13_12_11_10;
    out_ready = 1'b1;
    sel5      = 3'd0;
    in_valid5 = 5'b00000;
    in_data5  = 40'h44_33_22_11_00;

    // Reset held for two cycles with every channel valid.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_in_ready", 32'(rr_in_ready), 32'h0);
      check("rst_out_valid", 32'(rr_out_valid), 32'h0);
      check("rst_out_data", 32'(rr_out_data), 32'h00);
    end
    check("rst_ptr", 32'(dut_rr.ptr), 32'd3);
    rst = 1'b0;

    // Round-robin fairness: all valid, one word per cycle, ch 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      #1;
      check("rr_in_ready", 32'(rr_in_ready), 32'(1 << (i % 4)));
      tick();
      check("rr_out_valid", 32'(rr_out_valid), 32'h1);
      check("rr_out_ch", 32'(rr_out_ch), 32'(i % 4));
      check("rr_out_data", 32'(rr_out_data), 32'(8'h10 + (i % 4)));
    end

    // Backpressure: load 0xA5 from ch2, then stall three cycles.
    in_valid = 4'b0100;
    in_data  = 32'h13_A5_11_10;
    #1;
    check("bp_load_ready", 32'(rr_in_ready), 32'b0100);
    tick();
    check("bp_loaded", 32'(rr_out_data), 32'hA5);
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", 32'(rr_in_ready), 32'h0);
      tick();
      check("bp_hold_valid", 32'(rr_out_valid), 32'h1);
      check("bp_hold_data", 32'(rr_out_data), 32'hA5);
      check("bp_hold_ch", 32'(rr_out_ch), 32'd2);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(rr_in_ready), 32'b1000);
    tick();
    check("bp_next_ch", 32'(rr_out_ch), 32'd3);
    check("bp_next_data", 32'(rr_out_data), 32'h13);

    // Drain with no new input: out_valid clears.
    in_valid = 4'b0000;
    tick();
    check("drain_valid", 32'(rr_out_valid), 32'h0);

    // Wrap and skip: set ptr=2 via a ch2 transfer, then only ch0/ch1 valid.
    in_valid = 4'b0100;
    tick();
    check("wrap_ptr2", 32'(dut_rr.ptr), 32'd2);
    in_valid = 4'b0011;
    #1;
    check("wrap_ready0", 32'(rr_in_ready), 32'b0001);
    tick();
    check("wrap_ch0", 32'(rr_out_ch), 32'd0);
    check("wrap_ready1", 32'(rr_in_ready), 32'b0010);
    tick();
    check("wrap_ch1", 32'(rr_out_ch), 32'd1);
    check("wrap_ptr1", 32'(dut_rr.ptr), 32'd1);
    in_valid = 4'b0000;
    tick();

    // Mid-operation reset discards a stalled word.
    in_valid = 4'b0010;
    in_data  = 32'h13_12_5C_10;
    tick();
    check("mid_loaded", 32'(rr_out_data), 32'h5C);
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    tick();
    check("mid_hold", 32'(rr_out_data), 32'h5C);
    rst = 1'b1;
    in_valid = 4'b1111;
    #1;
    check("mid_rst_ready", 32'(rr_in_ready), 32'h0);
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(rr_out_valid), 32'h0);
    check("mid_rst_ptr", 32'(dut_rr.ptr), 32'd3);

    // Select mode: sel=3 with ch0 and ch3 valid accepts only ch3.
    out_ready = 1'b1;
    sel       = 2'd3;
    in_valid  = 4'b1001;
    in_data   = 32'h33_22_11_30;
    #1;
    check("sel_ready", 32'(s_in_ready), 32'b1000);
    tick();
    check("sel_ch", 32'(s_out_ch), 32'd3);
    check("sel_data", 32'(s_out_data), 32'h33);
    out_ready = 1'b0;
    #1;
    check("sel_stall_ready", 32'(s_in_ready), 32'h0);
    out_ready = 1'b1;
    in_valid  = 4'b0000;
    tick();

    // Out-of-range sel (5 with NCH=5): no grant, no load.
    sel5      = 3'd5;
    in_valid5 = 5'b11111;
    #1;
    check("sel5_ready", 32'(f_in_ready), 32'h0);
    tick();
    check("sel5_no_load", 32'(f_out_valid), 32'h0);
    // Highest legal index still works.
    sel5 = 3'd4;
    #1;
    check("sel4_ready", 32'(f_in_ready), 32'b10000);
    tick();
    check("sel4_ch", 32'(f_out_ch), 32'd4);
    check("sel4_data", 32'(f_out_data), 32'h44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
